// File: rtl/sram_sched_pkg.sv
// Shared constants for the SRAM round-robin scheduler: requester indices,
// write-request field slices and the read encoding of the byte mask.
package sram_sched_pkg;

    localparam logic [1:0] REQ_W0 = 2'd0;
    localparam logic [1:0] REQ_W1 = 2'd1;
    localparam logic [1:0] REQ_R0 = 2'd2;
    localparam logic [1:0] REQ_R1 = 2'd3;

    localparam int MASK_MSB = 53;
    localparam int MASK_LSB = 50;
    localparam int ADDR_MSB = 49;
    localparam int ADDR_LSB = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    localparam int REQ_W  = 54;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic [MASK_W-1:0] READ_MASK = 4'b0000;

    // Cyclic successor in the W0, W1, R0, R1 order; R1 wraps to W0.
    function automatic logic [1:0] req_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/sram_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the reader tag of each in-flight read.
// Push while full is accepted when a pop happens in the same cycle.
module sram_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     push_data_i,
    input  logic                     pop_i,
    output logic                     pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sram_rr_scheduler.sv
// Round-robin arbiter sharing one SRAM command port among two writers and two
// readers; read tags route returned data back to the issuing reader.
module sram_rr_scheduler
    import sram_sched_pkg::*;
#(
    parameter int TAG_DEPTH = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic        sram_clock,
    input  logic        reset_n,
    input  logic        w0_valid,
    input  logic        w1_valid,
    output logic        w0_pop,
    output logic        w1_pop,
    input  logic [53:0] w0_req,
    input  logic [53:0] w1_req,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_pop,
    output logic        r1_pop,
    input  logic [17:0] r0_addr,
    input  logic [17:0] r1_addr,
    input  logic        r0_afull,
    input  logic        r1_afull,
    output logic        sram_addr_valid,
    input  logic        sram_ready,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_data_in,
    output logic [3:0]  sram_write_mask,
    input  logic [31:0] sram_data_out,
    input  logic        sram_data_out_valid,
    output logic        r0_wr_en,
    output logic        r1_wr_en,
    output logic [31:0] r_wr_data,
    output logic        tag_err
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              cmd_vld_q, cmd_vld_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [MASK_W-1:0] cmd_mask_q, cmd_mask_d;
    logic [OW-1:0]     outst0_q, outst0_d;
    logic [OW-1:0]     outst1_q, outst1_d;
    logic              r0_wr_en_q, r1_wr_en_q;
    logic [DATA_W-1:0] r_wr_data_q;
    logic              tag_err_q;

    logic [3:0]        elig;
    logic              grant_en;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic              rd_gnt;
    logic              ret_ok;

    logic              tag_rd_data;
    logic              tag_full, tag_empty;
    logic [CW-1:0]     unused_tag_count;

    sram_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i       (sram_clock),
        .rst_ni      (reset_n),
        .push_i      (rd_gnt),
        .push_data_i (gnt_idx[0]),
        .pop_i       (ret_ok),
        .pop_data_o  (tag_rd_data),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (unused_tag_count)
    );

    always_comb begin
        elig         = '0;
        elig[REQ_W0] = w0_valid;
        elig[REQ_W1] = w1_valid;
        elig[REQ_R0] = r0_valid & ~r0_afull & (outst0_q < OW'(MAX_OUTST)) & ~tag_full;
        elig[REQ_R1] = r1_valid & ~r1_afull & (outst1_q < OW'(MAX_OUTST)) & ~tag_full;
    end

    // Pops are combinational, so grants must be suppressed while reset is held.
    assign grant_en = reset_n & (~cmd_vld_q | sram_ready);

    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr_q;
        idx     = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr_q + 2'(i);
            if (elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt_vld = gnt_vld & grant_en;
    end

    assign w0_pop = gnt_vld & (gnt_idx == REQ_W0);
    assign w1_pop = gnt_vld & (gnt_idx == REQ_W1);
    assign r0_pop = gnt_vld & (gnt_idx == REQ_R0);
    assign r1_pop = gnt_vld & (gnt_idx == REQ_R1);

    assign rd_gnt = gnt_vld & gnt_idx[1];
    assign ret_ok = sram_data_out_valid & ~tag_empty;

    always_comb begin
        rr_ptr_d   = gnt_vld ? req_next(gnt_idx) : rr_ptr_q;
        cmd_vld_d  = cmd_vld_q & ~sram_ready;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_mask_d = cmd_mask_q;
        if (gnt_vld) begin
            cmd_vld_d = 1'b1;
            case (gnt_idx)
                REQ_W0: begin
                    cmd_addr_d = w0_req[ADDR_MSB:ADDR_LSB];
                    cmd_data_d = w0_req[DATA_MSB:DATA_LSB];
                    cmd_mask_d = w0_req[MASK_MSB:MASK_LSB];
                end
                REQ_W1: begin
                    cmd_addr_d = w1_req[ADDR_MSB:ADDR_LSB];
                    cmd_data_d = w1_req[DATA_MSB:DATA_LSB];
                    cmd_mask_d = w1_req[MASK_MSB:MASK_LSB];
                end
                REQ_R0: begin
                    cmd_addr_d = r0_addr;
                    cmd_data_d = '0;
                    cmd_mask_d = READ_MASK;
                end
                default: begin
                    cmd_addr_d = r1_addr;
                    cmd_data_d = '0;
                    cmd_mask_d = READ_MASK;
                end
            endcase
        end
    end

    // A grant and a return on the same reader in one cycle leave the count unchanged.
    always_comb begin
        outst0_d = outst0_q + OW'(rd_gnt & ~gnt_idx[0]) - OW'(ret_ok & ~tag_rd_data);
        outst1_d = outst1_q + OW'(rd_gnt &  gnt_idx[0]) - OW'(ret_ok &  tag_rd_data);
    end

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= REQ_W0;
            cmd_vld_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_mask_q  <= '0;
            outst0_q    <= '0;
            outst1_q    <= '0;
            r0_wr_en_q  <= 1'b0;
            r1_wr_en_q  <= 1'b0;
            r_wr_data_q <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_mask_q  <= cmd_mask_d;
            outst0_q    <= outst0_d;
            outst1_q    <= outst1_d;
            r0_wr_en_q  <= ret_ok & ~tag_rd_data;
            r1_wr_en_q  <= ret_ok &  tag_rd_data;
            if (sram_data_out_valid) r_wr_data_q <= sram_data_out;
            if (sram_data_out_valid & tag_empty) tag_err_q <= 1'b1;
        end
    end

    assign sram_addr_valid = cmd_vld_q;
    assign sram_addr       = cmd_addr_q;
    assign sram_data_in    = cmd_data_q;
    assign sram_write_mask = cmd_mask_q;
    assign r0_wr_en        = r0_wr_en_q;
    assign r1_wr_en        = r1_wr_en_q;
    assign r_wr_data       = r_wr_data_q;
    assign tag_err         = tag_err_q;

endmodule

// File: tb/tb_sram_rr_scheduler.sv
// Directed bench for sram_rr_scheduler: arbitration order, stalls, read credit
// limits, tag-routed returns and reset behaviour.
module tb_sram_rr_scheduler;

    logic        sram_clock;
    logic        reset_n;
    logic        w0_valid, w1_valid;
    logic        w0_pop, w1_pop;
    logic [53:0] w0_req, w1_req;
    logic        r0_valid, r1_valid;
    logic        r0_pop, r1_pop;
    logic [17:0] r0_addr, r1_addr;
    logic        r0_afull, r1_afull;
    logic        sram_addr_valid;
    logic        sram_ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;
    logic        r0_wr_en, r1_wr_en;
    logic [31:0] r_wr_data;
    logic        tag_err;

    int errors = 0;
    int checks = 0;

    logic [3:0]  pops;
    assign pops = {w0_pop, w1_pop, r0_pop, r1_pop};

    logic [3:0]  exp_pop  [4];
    logic [17:0] exp_addr [4];
    logic [3:0]  exp_mask [4];
    logic [31:0] exp_data [4];

    sram_rr_scheduler #(
        .TAG_DEPTH (8),
        .MAX_OUTST (4)
    ) dut (
        .sram_clock          (sram_clock),
        .reset_n             (reset_n),
        .w0_valid            (w0_valid),
        .w1_valid            (w1_valid),
        .w0_pop              (w0_pop),
        .w1_pop              (w1_pop),
        .w0_req              (w0_req),
        .w1_req              (w1_req),
        .r0_valid            (r0_valid),
        .r1_valid            (r1_valid),
        .r0_pop              (r0_pop),
        .r1_pop              (r1_pop),
        .r0_addr             (r0_addr),
        .r1_addr             (r1_addr),
        .r0_afull            (r0_afull),
        .r1_afull            (r1_afull),
        .sram_addr_valid     (sram_addr_valid),
        .sram_ready          (sram_ready),
        .sram_addr           (sram_addr),
        .sram_data_in        (sram_data_in),
        .sram_write_mask     (sram_write_mask),
        .sram_data_out       (sram_data_out),
        .sram_data_out_valid (sram_data_out_valid),
        .r0_wr_en            (r0_wr_en),
        .r1_wr_en            (r1_wr_en),
        .r_wr_data           (r_wr_data),
        .tag_err             (tag_err)
    );

    initial begin
        sram_clock = 1'b0;
        forever #5 sram_clock = ~sram_clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs;
        w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
        w0_req = '0; w1_req = '0; r0_addr = '0; r1_addr = '0;
        r0_afull = 0; r1_afull = 0; sram_ready = 1;
        sram_data_out = '0; sram_data_out_valid = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 1'b0;
        @(negedge sram_clock);
        reset_n = 1'b1;
    endtask

    initial begin
        exp_pop  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        exp_addr = '{18'h00100, 18'h00200, 18'h00300, 18'h00400};
        exp_mask = '{4'h1, 4'h2, 4'h0, 4'h0};
        exp_data = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};

        clear_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", sram_addr_valid, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_data_in", sram_data_in, 0);
        chk("rst_mask", sram_write_mask, 0);
        chk("rst_wr_en", {r0_wr_en, r1_wr_en}, 0);
        chk("rst_wr_data", r_wr_data, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_pops", pops, 0);
        @(negedge sram_clock);
        @(negedge sram_clock);
        reset_n = 1'b1;

        // All four requesters continuously valid, SRAM always ready.
        w0_valid = 1; w1_valid = 1; r0_valid = 1; r1_valid = 1;
        w0_req = {4'h1, 18'h00100, 32'h11111111};
        w1_req = {4'h2, 18'h00200, 32'h22222222};
        r0_addr = 18'h00300; r1_addr = 18'h00400;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_pop%0d", k), pops, exp_pop[k % 4]);
            if (k == 0) begin
                chk("rr_valid0", sram_addr_valid, 0);
            end else begin
                chk($sformatf("rr_valid%0d", k), sram_addr_valid, 1);
                chk($sformatf("rr_addr%0d", k), sram_addr, exp_addr[(k-1) % 4]);
                chk($sformatf("rr_mask%0d", k), sram_write_mask, exp_mask[(k-1) % 4]);
                chk($sformatf("rr_data%0d", k), sram_data_in, exp_data[(k-1) % 4]);
            end
            @(negedge sram_clock);
        end

        // Move pointer to R0 with a single W1 grant, then only W0 requests.
        do_reset();
        w1_valid = 1; w1_req = {4'h3, 18'h00222, 32'h33333333};
        #1 chk("wrap_w1", pops, 4'b0100);
        @(negedge sram_clock);
        w1_valid = 0; w0_valid = 1; w0_req = {4'h4, 18'h00111, 32'h44444444};
        #1 chk("wrap_w0a", pops, 4'b1000);
        chk("wrap_addr_w1", sram_addr, 18'h00222);
        @(negedge sram_clock);
        #1 chk("wrap_w0b", pops, 4'b1000);
        chk("wrap_addr_w0", sram_addr, 18'h00111);
        @(negedge sram_clock);
        #1 chk("wrap_w0c", pops, 4'b1000);
        @(negedge sram_clock);
        w0_valid = 0;
        #1 chk("wrap_idle_pop", pops, 0);
        chk("wrap_last_valid", sram_addr_valid, 1);
        @(negedge sram_clock);
        #1 chk("wrap_drained", sram_addr_valid, 0);
        @(negedge sram_clock);

        // Tag routing of two reads with 3-cycle SRAM latency.
        do_reset();
        r0_valid = 1; r0_addr = 18'h00010;
        #1 chk("rd_pop_r0", pops, 4'b0010);
        @(negedge sram_clock);
        r0_valid = 0; r1_valid = 1; r1_addr = 18'h00020;
        #1 chk("rd_pop_r1", pops, 4'b0001);
        chk("rd_cmd_r0_addr", sram_addr, 18'h00010);
        chk("rd_cmd_r0_mask", sram_write_mask, 4'h0);
        @(negedge sram_clock);
        r1_valid = 0;
        #1 chk("rd_cmd_r1_addr", sram_addr, 18'h00020);
        chk("rd_cmd_r1_data", sram_data_in, 0);
        @(negedge sram_clock);
        #1 chk("rd_cmd_idle", sram_addr_valid, 0);
        @(negedge sram_clock);
        sram_data_out_valid = 1; sram_data_out = 32'hAAAA0000;
        @(negedge sram_clock);
        sram_data_out = 32'hBBBB0000;
        #1 chk("ret0_wr_en", {r0_wr_en, r1_wr_en}, 2'b10);
        chk("ret0_data", r_wr_data, 32'hAAAA0000);
        @(negedge sram_clock);
        sram_data_out_valid = 0;
        #1 chk("ret1_wr_en", {r0_wr_en, r1_wr_en}, 2'b01);
        chk("ret1_data", r_wr_data, 32'hBBBB0000);
        @(negedge sram_clock);
        #1 chk("ret_done_wr_en", {r0_wr_en, r1_wr_en}, 2'b00);
        chk("ret_no_err", tag_err, 0);
        @(negedge sram_clock);

        // Stall: W1 write held while sram_ready is low for 5 cycles.
        do_reset();
        sram_ready = 0;
        w1_valid = 1; w1_req = {4'hF, 18'h3FFFF, 32'hDEADBEEF};
        #1 chk("stall_first_pop", pops, 4'b0100);
        @(negedge sram_clock);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall_pop%0d", k), pops, 0);
            chk($sformatf("stall_cmd%0d", k),
                {sram_addr_valid, sram_write_mask, sram_addr, sram_data_in},
                {1'b1, 4'hF, 18'h3FFFF, 32'hDEADBEEF});
            @(negedge sram_clock);
        end
        sram_ready = 1;
        #1 chk("stall_release_pop", pops, 4'b0100);
        chk("stall_release_valid", sram_addr_valid, 1);
        @(negedge sram_clock);
        w1_valid = 0;
        #1 chk("stall_reload_valid", sram_addr_valid, 1);
        chk("stall_reload_pop", pops, 0);
        @(negedge sram_clock);
        #1 chk("stall_empty", sram_addr_valid, 0);
        @(negedge sram_clock);

        // Per-reader credit limit of 4 outstanding reads.
        do_reset();
        r0_valid = 1; r0_addr = 18'h00040;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("credit_r0_%0d", k), pops, 4'b0010);
            @(negedge sram_clock);
        end
        r1_valid = 1; r1_addr = 18'h00050;
        #1 chk("credit_r1_only", pops, 4'b0001);
        @(negedge sram_clock);
        r1_valid = 0;
        sram_data_out_valid = 1; sram_data_out = 32'hCAFE0001;
        #1 chk("credit_r0_blocked", pops, 0);
        @(negedge sram_clock);
        sram_data_out_valid = 0;
        #1 chk("credit_r0_again", pops, 4'b0010);
        chk("credit_ret_wr_en", {r0_wr_en, r1_wr_en}, 2'b10);
        chk("credit_ret_data", r_wr_data, 32'hCAFE0001);
        @(negedge sram_clock);
        r0_valid = 0;
        #1 chk("credit_idle", pops, 0);
        @(negedge sram_clock);

        // Return strobe with nothing outstanding, then reset mid-burst.
        do_reset();
        sram_data_out_valid = 1; sram_data_out = 32'h12345678;
        @(negedge sram_clock);
        sram_data_out_valid = 0;
        #1 chk("orphan_tag_err", tag_err, 1);
        chk("orphan_wr_en", {r0_wr_en, r1_wr_en}, 2'b00);
        @(negedge sram_clock);
        #1 chk("orphan_sticky", tag_err, 1);
        @(negedge sram_clock);
        w0_valid = 1; w1_valid = 1; r0_valid = 1; r1_valid = 1;
        w0_req = {4'h1, 18'h00100, 32'h11111111};
        w1_req = {4'h2, 18'h00200, 32'h22222222};
        @(negedge sram_clock);
        @(negedge sram_clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", sram_addr_valid, 0);
        chk("midrst_cmd", {sram_addr, sram_data_in, sram_write_mask}, 0);
        chk("midrst_tag_err", tag_err, 0);
        chk("midrst_pops", pops, 0);
        chk("midrst_ret", {r0_wr_en, r1_wr_en, r_wr_data}, 0);
        @(negedge sram_clock);
        reset_n = 1'b1;
        #1 chk("midrst_ptr_w0", pops, 4'b1000);
        @(negedge sram_clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
